// File: rtl/ifu_fetch_pkg.sv
// Shared widths, fetch state encodings and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

    localparam int unsigned INSTWide = 32;
    localparam int unsigned RegWidth = 64;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [INSTWide-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [RegWidth-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Payload handed to decode.
    typedef struct packed {
        logic [RegWidth-1:0] pc;
        logic [INSTWide-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/ifu_fetch_reg.sv
// Generic enable register with a synchronous active-low reset to a fixed value.
module ifu_fetch_reg #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time and hands
// each instruction to decode; redirects squash every old-path fetch.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [RegWidth-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [RegWidth-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTWide-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [RegWidth-1:0] redirect_pc,
    output logic                ifu_valid,
    input  logic                idu_ready,
    output logic [INSTWide-1:0] id_inst,
    output logic [RegWidth-1:0] id_pc
);

    localparam int unsigned XLEN = RegWidth;
    localparam int unsigned PktW = $bits(fetch_pkt_t);
    localparam logic [PktW-1:0] PktRst = PktW'({XLEN'(0), NOP_INST});

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            kill_q, kill_d;
    fetch_pkt_t      id_pkt_q, id_pkt_d;
    logic            req_valid_q, req_valid_d;
    logic            ifu_valid_q, ifu_valid_d;
    logic            req_hs;
    logic [XLEN-1:0] redirect_tgt;

    // Next-state logic; a redirect overrides every normal transition.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        kill_d        = kill_q;
        id_pkt_d      = id_pkt_q;
        req_hs        = req_valid_q && imem_req_ready;
        redirect_tgt  = redirect_pc & ~XLEN'(3);

        if (redirect_valid) begin
            pc_d = redirect_tgt;
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        state_d       = S_WAIT;
                        pc_inflight_d = pc_q;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            id_pkt_d.pc   = pc_inflight_q;
                            id_pkt_d.inst = imem_rsp_data;
                            pc_d          = pc_inflight_q + XLEN'(4);
                            state_d       = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (idu_ready) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        req_valid_d = (state_d == S_REQ);
        ifu_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    ifu_fetch_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(1'b1), .d(pc_d), .q(pc_q)
    );

    ifu_fetch_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_inflight (
        .clk(clk), .rst(rst), .en(1'b1), .d(pc_inflight_d), .q(pc_inflight_q)
    );

    ifu_fetch_reg #(.W(1), .RST_VAL(1'b0)) u_kill (
        .clk(clk), .rst(rst), .en(1'b1), .d(kill_d), .q(kill_q)
    );

    ifu_fetch_reg #(.W(PktW), .RST_VAL(PktRst)) u_id_pkt (
        .clk(clk), .rst(rst), .en(1'b1), .d(id_pkt_d), .q(id_pkt_q)
    );

    // Handshake flags held low throughout reset.
    ifu_fetch_reg #(.W(1), .RST_VAL(1'b0)) u_req_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(req_valid_d), .q(req_valid_q)
    );

    ifu_fetch_reg #(.W(1), .RST_VAL(1'b0)) u_ifu_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(ifu_valid_d), .q(ifu_valid_q)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign ifu_valid      = ifu_valid_q;
    assign id_inst        = id_pkt_q.inst;
    assign id_pc          = id_pkt_q.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory model, transaction-level reference and literal checks.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        ifu_valid;
    logic        idu_ready = 1'b1;
    logic [31:0] id_inst;
    logic [63:0] id_pc;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ifu_valid(ifu_valid),
        .idu_ready(idu_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_000C) return 32'h0050_0093;
        return 32'(a >> 2) ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: accepts one request, answers mem_lat edges later, dropped by reset.
    initial begin : memory
        logic        m_rst, m_acc;
        logic [63:0] m_addr_s, m_addr;
        int          cnt;
        cnt = 0;
        m_addr = '0;
        forever begin
            @(negedge clk);
            m_rst = rst;
            m_acc = imem_req_valid && imem_req_ready;
            m_addr_s = imem_addr;
            @(posedge clk);
            #1;
            if (!m_rst) begin
                cnt = 0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (m_acc) begin
                    cnt = mem_lat;
                    m_addr = m_addr_s;
                end
                if (cnt == 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = inst_of(m_addr);
                    cnt = 0;
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data = 32'h0;
                    if (cnt > 1) cnt--;
                end
            end
        end
    end

    // Reference: expected fetch stream, live/stale request and held instruction.
    initial begin : model
        logic [63:0] exp_next, out_addr, hold_pc;
        logic        live, hold, rst_edge, acc;
        exp_next = RST_PC;
        out_addr = '0;
        hold_pc = '0;
        live = 1'b0;
        hold = 1'b0;
        rst_edge = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("m_ifu_valid", ifu_valid, hold);
            chk("m_req_and_valid", imem_req_valid && ifu_valid, 0);
            if (rst_edge) chk("m_req_in_reset", imem_req_valid, 0);
            if (hold) begin
                chk("m_id_pc", id_pc, hold_pc);
                chk("m_id_inst", id_inst, inst_of(hold_pc));
            end
            if (imem_req_valid) chk("m_imem_addr", imem_addr, exp_next);
            acc = imem_req_valid && imem_req_ready;
            rst_edge = !rst;
            if (!rst) begin
                exp_next = RST_PC;
                live = 1'b0;
                hold = 1'b0;
            end else if (redirect_valid) begin
                exp_next = redirect_pc & ~64'h3;
                live = 1'b0;
                hold = 1'b0;
            end else begin
                if (hold && idu_ready) hold = 1'b0;
                if (imem_rsp_valid && live) begin
                    hold = 1'b1;
                    hold_pc = out_addr;
                    exp_next = out_addr + 64'd4;
                    live = 1'b0;
                end
                if (acc) begin
                    live = 1'b1;
                    out_addr = imem_addr;
                end
            end
        end
    end

    task automatic wait_req(input bit quiet, output int n);
        n = 0;
        while (!imem_req_valid && n < 20) begin
            if (quiet) chk("no_valid_while_squashed", ifu_valid, 0);
            step();
            n++;
        end
        chk("req_timeout", imem_req_valid, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ifu_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_timeout", ifu_valid, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        repeat (3) step();
        chk("rst_ifu_valid", ifu_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_inst", id_inst, 64'h13);
        chk("rst_id_pc", id_pc, 0);
        rst = 1'b1;
        imem_req_ready = 1'b1;

        // Zero-wait stream, three cycles per instruction.
        for (int k = 0; k < 3; k++) begin
            wait_req(1'b0, n);
            if (k > 0) chk("req_gap", n, 1);
            chk("stream_addr", imem_addr, RST_PC + 64'(4 * k));
            wait_valid(n);
            chk("stream_latency", n, 2);
            chk("stream_id_pc", id_pc, RST_PC + 64'(4 * k));
        end
        step();
        idu_ready = 1'b0;
        wait_valid(n);
        chk("stall_inst", id_inst, 64'h0050_0093);
        chk("stall_pc", id_pc, 64'h8000_000C);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", ifu_valid, 1);
            chk("stall_no_req", imem_req_valid, 0);
            chk("stall_inst_hold", id_inst, 64'h0050_0093);
        end

        // Memory not ready, then latency 3.
        idu_ready = 1'b1;
        imem_req_ready = 1'b0;
        mem_lat = 3;
        step();
        chk("next_after_stall", imem_addr, 64'h8000_0010);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("notready_req", imem_req_valid, 1);
            chk("notready_addr", imem_addr, 64'h8000_0010);
        end
        imem_req_ready = 1'b1;
        step();
        wait_valid(n);
        chk("lat3_latency", n, 3);
        chk("lat3_pc", id_pc, 64'h8000_0010);

        // Redirect while waiting for a response.
        wait_req(1'b0, n);
        chk("pre_redirect_addr", imem_addr, 64'h8000_0014);
        step();
        chk("in_wait", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        wait_req(1'b1, n);
        chk("redirect_addr", imem_addr, 64'h8000_0100);
        wait_valid(n);
        chk("redirect_id_pc", id_pc, 64'h8000_0100);
        chk("redirect_id_inst", id_inst, 64'h3357_0040);

        // Redirect in hold together with idu_ready, misaligned target.
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0203;
        step();
        redirect_valid = 1'b0;
        chk("hold_redirect_valid", ifu_valid, 0);
        chk("hold_redirect_req", imem_req_valid, 1);
        chk("hold_redirect_addr", imem_addr, 64'h8000_0200);

        // Redirect coinciding with the request handshake; target at top of memory.
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("hs_redirect_req", imem_req_valid, 0);
        wait_req(1'b1, n);
        chk("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid(n);
        chk("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_next_req", imem_req_valid, 1);
        chk("wrap_next_addr", imem_addr, 64'h0);

        // Reset in the middle of a fetch.
        step();
        chk("pre_reset_wait", imem_req_valid, 0);
        rst = 1'b0;
        step();
        chk("midrst_valid", ifu_valid, 0);
        chk("midrst_req", imem_req_valid, 0);
        chk("midrst_inst", id_inst, 64'h13);
        rst = 1'b1;
        wait_req(1'b1, n);
        chk("midrst_addr", imem_addr, RST_PC);
        wait_valid(n);
        chk("midrst_id_pc", id_pc, RST_PC);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the architectural PC and issues one 32-bit instruction fetch at a time over a simple request/response memory port.
- Presents each fetched instruction with its PC to decode under a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) from later stages; every fetch in flight or held for the old path is squashed.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; equals the internal PC.
- imem_rsp_valid  in  1  response valid; one cycle, no backpressure.
- imem_rsp_data  in  ILEN  fetched instruction.
- redirect_valid  in  1  redirect next fetch.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0 internally.
- ifu_valid  out  1  id_inst/id_pc valid toward decode.
- idu_ready  in  1  decode accepts this cycle.
- id_inst  out  ILEN  instruction to decode.
- id_pc  out  XLEN  PC of id_inst.

Behaviour:
- Reset (rst == 0 at an edge):
  - state = S_REQ, pc = RESET_PC, kill = 0.
  - id_inst = 32'h0000_0013 (NOP), id_pc = 0.
  - ifu_valid = 0, imem_req_valid = 0 during reset.
  - Reset mid-fetch discards any pending response. The memory is reset by the same rst, so no stale response follows.
- States: S_REQ, S_WAIT, S_HOLD. At most one outstanding request.
- Outputs are Moore-style:
  - imem_req_valid = (state == S_REQ).
  - ifu_valid = (state == S_HOLD).
  - imem_addr = pc.
  - id_inst and id_pc are registered.
- S_REQ:
  - If imem_req_ready, go to S_WAIT and capture pc_inflight = pc.
  - Otherwise hold; address stays stable until accepted.
- S_WAIT, on imem_rsp_valid:
  - If kill = 1: drop the data, clear kill, go to S_REQ.
  - Else: id_inst = imem_rsp_data, id_pc = pc_inflight, pc = pc_inflight + 4 (mod 2^XLEN, wraps silently), go to S_HOLD.
- S_HOLD:
  - ifu_valid = 1; id_inst and id_pc stay stable while idu_ready = 0.
  - On idu_ready, go to S_REQ. The next request is visible the following cycle.
- Redirect has priority over all other transitions in the same cycle. pc = {redirect_pc[XLEN-1:2], 2'b00}, then:
  - S_REQ, no handshake this cycle: stay in S_REQ; the new address appears next cycle.
  - S_REQ with handshake this same cycle: go to S_WAIT with kill = 1; the old-path response will be dropped.
  - S_WAIT, no response this cycle: set kill = 1, stay in S_WAIT.
  - S_WAIT with response this same cycle: drop the response, go to S_REQ.
  - S_HOLD, with or without idu_ready: drop the held instruction, ifu_valid = 0 next cycle, go to S_REQ.
- Throughput: at least 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory.
- Latency: for a first accept at cycle t, ifu_valid rises at t+1+memlat, where memlat ≥ 1 is the response delay in cycles.
- Not checked: imem_rsp_valid outside S_WAIT is ignored (protocol error, assertion in bench).

Decomposition:
- Shared defines file additions:
  - Widths INSTWide (32) and RegWidth (64), used for ILEN and XLEN.
  - Fetch state encodings S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2.
  - NOP constant 32'h0000_0013.
  - RESET_PC default.
- No sub-module. PC, pc_inflight, kill and output registers use the existing generic enable register cell, with the reset value and polarity adapted to active-low synchronous reset.

Test Plan:
- Reset then zero-wait memory, idu_ready = 1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; ifu_valid pulses one cycle per 3; id_pc matches each address.
- idu_ready = 0 for 5 cycles in S_HOLD with id_inst = 0x00500093 → id_inst and id_pc stable, no new imem_req_valid; release → next request at id_pc + 4.
- imem_req_ready low 4 cycles → imem_addr stable, imem_req_valid held; response latency 3 → ifu_valid exactly 3 cycles after the response is requested.
- Redirect to 0x8000_0100 while in S_WAIT (response 2 cycles later) → that response is dropped, ifu_valid stays 0, next request address 0x8000_0100, delivered id_pc = 0x8000_0100.
- Redirect in S_HOLD simultaneous with idu_ready = 1, redirect_pc = 0x8000_0203 → ifu_valid 0 next cycle, next request address 0x8000_0200.
- pc = 0xFFFF_FFFF_FFFF_FFFC fetch accepted → following request address 0x0; rst asserted low during S_WAIT → state S_REQ, pc = RESET_PC, ifu_valid = 0.
